// File: rtl/mips_multicycle_sequencer_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_sequencer_if
//   Memory-side handshake bundle of the multi-cycle sequencer: one req/ack
//   channel to instruction memory and one to data memory.
//
//   imem_req    sequencer -> imem   fetch request, held until imem_ack
//   imem_addr   sequencer -> imem   word address of the fetch (the PC)
//   imem_ack    imem -> sequencer   fetch complete, imem_rdata valid this cycle
//   imem_rdata  imem -> sequencer   fetched instruction word
//   dmem_req    sequencer -> dmem   data access request, held until dmem_ack
//   dmem_we     sequencer -> dmem   1 = store, 0 = load (qualified by dmem_req)
//   dmem_ack    dmem -> sequencer   data access complete
//
//   master: the sequencer side.  slave: the memory side.
// ---------------------------------------------------------------------------
interface mips_multicycle_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic              dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/mips_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// mips_multicycle_sequencer
//   Multi-cycle control sequencer of the mini MIPS core. Owns the PC, the
//   instruction register and the retired-instruction counter, and steps each
//   instruction through FETCH/DECODE/EXEC/MEM/WB. Both memories are reached
//   over req/ack handshakes, so any memory latency is tolerated.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   start              leave IDLE and begin fetching at PC 0
//   bus                imem/dmem handshake bundle (master side)
//   instr              instruction register
//   dec_*              decoder flags for the instruction in IR
//   br_taken           branch compare result, valid in EXEC
//   jr_target          rs value (byte address) for jr, valid in EXEC
//   rf_we              one-cycle register-file write enable (WB only)
//   pc                 current PC (word address)
//   state              IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6
//   halted             high while in HALT
//   retired            saturating count of completed instructions
// ---------------------------------------------------------------------------
module mips_multicycle_sequencer #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    mips_multicycle_sequencer_if.master bus,
    output logic [31:0]              instr,
    input  logic                     dec_branch,
    input  logic                     dec_jump,
    input  logic                     dec_jr,
    input  logic                     dec_mem_rd,
    input  logic                     dec_mem_wr,
    input  logic                     dec_reg_wr,
    input  logic                     dec_halt,
    input  logic                     br_taken,
    input  logic [31:0]              jr_target,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        pc,
    output logic [2:0]               state,
    output logic                     halted,
    output logic [CNT_W-1:0]         retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_next_q, pc_next_d;
    logic [ADDR_W-1:0] pc_seq;
    logic [31:0]       ir_q;
    logic [CNT_W-1:0]  retired_q;
    logic              ir_load;
    logic              pc_next_load;
    logic              retire;

    // Branch immediate sign-extended and reduced to the PC width; wrapping
    // arithmetic on the truncated value equals arithmetic mod 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] sext_imm(input logic [15:0] imm);
        logic signed [31:0] wide;
        wide = {{16{imm[15]}}, imm};
        return wide[ADDR_W-1:0];
    endfunction

    // Retired counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Only the word-address bits of the jr byte address matter.
    logic unused_jr_bits;
    assign unused_jr_bits = ^{jr_target[31:ADDR_W+2], jr_target[1:0]};

    assign pc_seq = pc_q + ADDR_W'(1);

    // Next-PC selection, priority jr > jump > taken branch > sequential.
    always_comb begin
        pc_next_d = pc_seq;
        if (dec_jr)
            pc_next_d = jr_target[ADDR_W+1:2];
        else if (dec_jump)
            pc_next_d = ir_q[ADDR_W-1:0];
        else if (dec_branch && br_taken)
            pc_next_d = pc_seq + sext_imm(ir_q[15:0]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        ir_load      = 1'b0;
        pc_next_load = 1'b0;
        retire       = 1'b0;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        rf_we        = 1'b0;
        halted       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = dec_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                pc_next_load = 1'b1;
                state_d      = (dec_mem_rd || dec_mem_wr) ? S_MEM : S_WB;
            end
            S_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = dec_mem_wr;
                if (bus.dmem_ack) begin
                    // Stores have nothing to write back, so they retire here.
                    if (dec_mem_wr) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = dec_reg_wr;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= '0;
            pc_next_q <= '0;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            if (ir_load)
                ir_q <= bus.imem_rdata;
            if (pc_next_load)
                pc_next_q <= pc_next_d;
            if (retire) begin
                pc_q      <= pc_next_q;
                retired_q <= sat_inc(retired_q);
            end
        end
    end

    assign bus.imem_addr = pc_q;
    assign instr         = ir_q;
    assign pc            = pc_q;
    assign state         = state_q;
    assign retired       = retired_q;

endmodule
